// File: rtl/fir4_avg_out_stage_pkg.sv
// Shared defaults, types and arithmetic constants for the FIR averaging output stage.
package fir4_pkg;

   localparam int FIR4_W      = 16;          // sample width
   localparam int FIR4_WARMUP = 3;           // sums discarded after reset
   localparam int FIR4_DEPTH  = 4;           // output FIFO entries
   localparam int SUM_W       = FIR4_W + 2;  // tap-sum width

   localparam int ROUND_BIAS  = 2;           // half of the divisor, for round-half-up
   localparam int SHIFT       = 2;           // divide by 4

   typedef logic signed [FIR4_W-1:0] sample_t;
   typedef logic signed [SUM_W-1:0]  sum_t;

   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } avg_state_e;

endpackage

// File: rtl/fir4_avg_out_stage_if.sv
// Sum input and averaged output handshake bundle of the averaging stage.
// slave: the averaging stage itself; master: the surrounding producer/sink.
interface fir4_avg_out_stage_if #(parameter int W = fir4_pkg::FIR4_W) ();

   logic [W+1:0] sum_in;
   logic         sum_valid;
   logic [W-1:0] avg_out;
   logic         avg_valid;
   logic         avg_ready;

   modport slave (
      input  sum_in,
      input  sum_valid,
      output avg_out,
      output avg_valid,
      input  avg_ready
   );

   modport master (
      output sum_in,
      output sum_valid,
      input  avg_out,
      input  avg_valid,
      output avg_ready
   );

endinterface

// File: rtl/fir4_avg_out_stage_sync_fifo.sv
// Synchronous FIFO whose head entry lives in a dedicated register, so the
// output data and valid come straight from flops. No write-to-read bypass:
// a write into an empty FIFO becomes visible on the following cycle.
module fir4_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             head_valid_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    rd_next;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   // A push into a full FIFO only lands if a pop frees a slot on the same edge.
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rd_next = rd_ptr_q + AW'(1);

   // Next pointers, occupancy and the value the head register should hold.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_next;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_ok && empty_o) begin
         head_d = wdata_i;
      end else if (pop_ok) begin
         // With a single entry left, the only possible successor is the word being pushed now.
         if (count_q == CW'(1)) begin
            if (push_ok) head_d = wdata_i;
         end else begin
            head_d = mem_q[rd_next];
         end
      end
   end

   // Storage array; data needs no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
      end
   end

   assign head_o       = head_q;
   assign head_valid_o = valid_q;

endmodule

// File: rtl/fir4_avg_out_stage.sv
// Averaging output stage: rounds the 4-tap sum down to a sample (divide by 4,
// round half up, saturate), discards the warm-up sums after reset, and queues
// averages in a FIFO behind a valid/ready handshake with overflow tracking.
module fir4_avg_out_stage
   import fir4_pkg::*;
#(
   parameter int W      = FIR4_W,
   parameter int WARMUP = FIR4_WARMUP,
   parameter int DEPTH  = FIR4_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   fir4_avg_out_stage_if.slave      bus,
   input  logic                     clr_ovf,
   output logic                     ovf_sticky,
   output logic [7:0]               drop_cnt
);

   localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic signed [W+2:0] AVG_MAX = (W+3)'((1 << (W - 1)) - 1);
   localparam logic signed [W+2:0] AVG_MIN = ~AVG_MAX;

   avg_state_e          state_q, state_d;
   logic [WCW-1:0]      warm_cnt_q, warm_cnt_d;
   logic                accept;
   logic signed [W+2:0] t_sum;
   logic signed [W+2:0] q_sum;
   logic [W-1:0]        s1_data_d;
   logic [W-1:0]        s1_data_q;
   logic                s1_valid_q;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic                drop;
   logic                ovf_q, ovf_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;

   // Warm-up FSM: count and swallow the first WARMUP sums, then pass everything.
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      accept     = 1'b0;
      case (state_q)
         WARM: begin
            if (bus.sum_valid) begin
               warm_cnt_d = warm_cnt_q + WCW'(1);
               if (warm_cnt_q == WCW'(WARMUP - 1)) state_d = RUN;
            end
         end
         RUN:     accept = bus.sum_valid;
         default: state_d = WARM;
      endcase
   end

   // FSM state and warm-up counter; a zero-length warm-up starts directly in RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= (WARMUP == 0) ? RUN : WARM;
         warm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
      end
   end

   // Divide by 4 with round-half-up, then saturate to the signed sample range.
   always_comb begin
      t_sum = $signed({bus.sum_in[W+1], bus.sum_in}) + $signed((W+3)'(ROUND_BIAS));
      q_sum = t_sum >>> SHIFT;
      if (q_sum > AVG_MAX) begin
         s1_data_d = AVG_MAX[W-1:0];
      end else if (q_sum < AVG_MIN) begin
         s1_data_d = AVG_MIN[W-1:0];
      end else begin
         s1_data_d = q_sum[W-1:0];
      end
   end

   // Stage-1 register holding the rounded average ahead of the FIFO write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) s1_data_q <= s1_data_d;
      end
   end

   assign fifo_pop = bus.avg_ready && !fifo_empty;
   // A stage-1 result is lost only when the FIFO is full and nothing leaves this cycle.
   assign drop     = s1_valid_q && fifo_full && !fifo_pop;

   fir4_sync_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .push_i       (s1_valid_q),
      .wdata_i      (s1_data_q),
      .pop_i        (fifo_pop),
      .head_o       (bus.avg_out),
      .head_valid_o (bus.avg_valid),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   // Overflow flag (a drop beats a simultaneous clear) and saturating drop counter.
   always_comb begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ovf_sticky = ovf_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fir4_avg_out_stage.sv
// Directed bench for the averaging output stage. Stimulus pushes hand-computed
// averages into a scoreboard queue; a monitor on the falling edge pops and
// compares on every handshake and checks the held head while stalled.
module tb_fir4_avg_out_stage;
   import fir4_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       clr_ovf;
   logic       ovf_sticky;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   fir4_avg_out_stage_if #(.W(FIR4_W)) bus ();

   fir4_avg_out_stage #(
      .W      (FIR4_W),
      .WARMUP (FIR4_WARMUP),
      .DEPTH  (FIR4_DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .clr_ovf    (clr_ovf),
      .ovf_sticky (ovf_sticky),
      .drop_cnt   (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input integer act, input integer exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // One sum per cycle; keep=1 means the average must eventually come out.
   task automatic send(input int s, input bit keep, input int e);
      bus.sum_in    = sum_t'(s);
      bus.sum_valid = 1'b1;
      if (keep) exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.sum_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         idle(1);
      end
      check(name, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: sampled mid-cycle, ahead of the edge that completes the handshake.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (bus.avg_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: got %0d expected no output", $signed(bus.avg_out));
            end else if (bus.avg_ready === 1'b1) begin
               e = exp_q.pop_front();
               check("pop", $signed(bus.avg_out), e);
            end else begin
               check("stall_head", $signed(bus.avg_out), exp_q[0]);
            end
         end
      end
   end

   initial begin
      reset_n       = 1'b0;
      clr_ovf       = 1'b0;
      bus.sum_in    = '0;
      bus.sum_valid = 1'b0;
      bus.avg_ready = 1'b0;
      #22;
      check("rst_valid", bus.avg_valid, 0);
      check("rst_data", $signed(bus.avg_out), 0);
      check("rst_ovf", ovf_sticky, 0);
      check("rst_drop", drop_cnt, 0);
      #5 reset_n = 1'b1;
      idle(1);

      // 1: warm-up discards three sums, then latency of two edges
      bus.avg_ready = 1'b1;
      send(4, 0, 0);
      send(8, 0, 0);
      send(12, 0, 0);
      send(16, 1, 4);
      check("t1_lat_edge1_valid", bus.avg_valid, 0);
      idle(1);
      check("t1_lat_edge2_valid", bus.avg_valid, 1);
      check("t1_lat_edge2_data", $signed(bus.avg_out), 4);
      wait_drain("t1_drain");

      // 2: rounding and saturation
      send(6, 1, 2);
      send(-6, 1, -1);
      send(5, 1, 1);
      send(-5, 1, -1);
      send(131068, 1, 32767);
      send(-131072, 1, -32768);
      send(131071, 1, 32767);
      wait_drain("t2_drain");
      check("t2_ovf", ovf_sticky, 0);

      // 3: back-pressure, two drops
      bus.avg_ready = 1'b0;
      send(40, 1, 10);
      send(44, 1, 11);
      send(48, 1, 12);
      send(52, 1, 13);
      send(56, 0, 0);
      send(60, 0, 0);
      idle(2);
      check("t3_ovf", ovf_sticky, 1);
      check("t3_drop", drop_cnt, 2);
      check("t3_head", $signed(bus.avg_out), 10);
      bus.avg_ready = 1'b1;
      wait_drain("t3_drain");

      // 4: full FIFO with push and pop on the same edge
      bus.avg_ready = 1'b0;
      send(100, 1, 25);
      send(104, 1, 26);
      send(108, 1, 27);
      send(112, 1, 28);
      idle(2);
      send(116, 1, 29);
      bus.avg_ready = 1'b1;
      idle(1);
      bus.avg_ready = 1'b0;
      check("t4_drop", drop_cnt, 2);
      check("t4_head", $signed(bus.avg_out), 26);
      idle(1);
      check("t4_drop_later", drop_cnt, 2);
      bus.avg_ready = 1'b1;
      wait_drain("t4_drain");

      // 5: clear alone, then clear colliding with a drop
      clr_ovf = 1'b1;
      idle(1);
      clr_ovf = 1'b0;
      check("t5_clr_ovf", ovf_sticky, 0);
      check("t5_clr_drop", drop_cnt, 2);
      bus.avg_ready = 1'b0;
      send(200, 1, 50);
      send(204, 1, 51);
      send(208, 1, 52);
      send(212, 1, 53);
      send(218, 0, 0);
      clr_ovf = 1'b1;
      idle(1);
      clr_ovf = 1'b0;
      check("t5_set_wins", ovf_sticky, 1);
      check("t5_drop", drop_cnt, 3);
      bus.avg_ready = 1'b1;
      wait_drain("t5_drain");

      // 6: asynchronous reset mid-cycle with entries queued
      bus.avg_ready = 1'b0;
      send(300, 1, 75);
      send(304, 1, 76);
      send(308, 1, 77);
      idle(2);
      check("t6_pre_valid", bus.avg_valid, 1);
      check("t6_pre_head", $signed(bus.avg_out), 75);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_valid", bus.avg_valid, 0);
      check("t6_rst_data", $signed(bus.avg_out), 0);
      check("t6_rst_ovf", ovf_sticky, 0);
      check("t6_rst_drop", drop_cnt, 0);
      exp_q.delete();
      #4 reset_n = 1'b1;
      idle(1);
      bus.avg_ready = 1'b1;
      send(400, 0, 0);
      send(404, 0, 0);
      send(408, 0, 0);
      send(412, 1, 103);
      wait_drain("t6_drain");
      idle(4);
      check("final_empty", bus.avg_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
